mem_arbiter: RTL and testbench

- Two-master, single-port data-memory arbiter with a request/acknowledge handshake.
- Master 0 is the CPU load/store port; master 1 is a DMA/debug loader.
- Serialises their word accesses onto one synchronous RAM with a fixed read latency.
- Round-robin arbitration, one outstanding transaction at a time.

---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous RAM.
// One transaction is in flight at a time. Requests are sampled only in IDLE,
// and every output is registered.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state;
    logic               last;
    logic [CNT_W-1:0]   cnt;
    logic               grant_vld;
    logic               winner;

    // Round-robin pick: a lone requester wins outright; on a tie the master
    // that was not served last wins.
    always_comb begin
        grant_vld = m0_req | m1_req;
        winner    = 1'b0;
        if (m0_req && m1_req)
            winner = ~last;
        else
            winner = m1_req;
    end

    // Transaction FSM with registered handshake, memory and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            cnt       <= '0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            owner     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        owner     <= winner;
                        last      <= winner;
                        mem_en    <= 1'b1;
                        mem_we    <= winner ? m1_we    : m0_we;
                        mem_addr  <= winner ? m1_addr  : m0_addr;
                        mem_wdata <= winner ? m1_wdata : m0_wdata;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    cnt    <= '0;
                    if (mem_we) begin
                        // Writes complete as soon as the strobe has been seen.
                        if (owner) m1_ack <= 1'b1;
                        else       m0_ack <= 1'b1;
                        state <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == CNT_W'(RD_LATENCY - 1)) begin
                        // Only the owner's read-data register is touched.
                        if (owner) begin
                            m1_rdata <= mem_rdata;
                            m1_ack   <= 1'b1;
                        end else begin
                            m0_rdata <= mem_rdata;
                            m0_ack   <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. The instance "dut" uses RD_LATENCY=1 and a
// storage RAM model. The instance "dut3" uses RD_LATENCY=3 and a RAM whose
// read data is a fixed function of the address. Between valid slots each RAM
// model drives a poison value.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;

    logic        a_m0_req, a_m0_we, a_m0_ack, a_m1_req, a_m1_we, a_m1_ack;
    logic [31:0] a_m0_addr, a_m0_wdata, a_m0_rdata, a_m1_addr, a_m1_wdata, a_m1_rdata;
    logic        a_mem_en, a_mem_we, a_busy, a_owner;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    logic        b_m0_req, b_m0_we, b_m0_ack, b_m1_req, b_m1_we, b_m1_ack;
    logic [31:0] b_m0_addr, b_m0_wdata, b_m0_rdata, b_m1_addr, b_m1_wdata, b_m1_rdata;
    logic        b_mem_en, b_mem_we, b_busy, b_owner;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
        .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata),
        .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
        .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .busy(a_busy), .owner(a_owner)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .busy(b_busy), .owner(b_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Latency-1 RAM: the read word is valid only in the cycle after the strobe.
    logic [31:0] ram_a [0:255];
    always @(posedge clk) begin
        if (a_mem_en && a_mem_we) ram_a[a_mem_addr[7:0]] <= a_mem_wdata;
        if (a_mem_en && !a_mem_we) a_mem_rdata <= ram_a[a_mem_addr[7:0]];
        else                       a_mem_rdata <= 32'hBADBAD01;
    end

    // Latency-3 RAM: data = {addr[15:0], ~addr[15:0]}, valid only in slot 3.
    logic [2:0]  b_v;
    logic [31:0] b_d [0:2];
    always @(posedge clk) begin
        b_v[0] <= b_mem_en && !b_mem_we;
        b_d[0] <= {b_mem_addr[15:0], ~b_mem_addr[15:0]};
        b_v[1] <= b_v[0];
        b_d[1] <= b_d[0];
        b_v[2] <= b_v[1];
        b_d[2] <= b_d[1];
    end
    assign b_mem_rdata = b_v[2] ? b_d[2] : 32'hBADBAD03;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        {a_m0_req, a_m0_we, a_m1_req, a_m1_we} = '0;
        {a_m0_addr, a_m0_wdata, a_m1_addr, a_m1_wdata} = '0;
        {b_m0_req, b_m0_we, b_m1_req, b_m1_we} = '0;
        {b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata} = '0;
        #1 rst = 1'b0;
        #1;
        // Reset state
        chk("rst_mem_en", a_mem_en, 0);
        chk("rst_busy",   a_busy,   0);
        chk("rst_owner",  a_owner,  0);
        chk("rst_acks",   {a_m0_ack, a_m1_ack}, 0);
        chk("rst_rdata",  a_m0_rdata, 0);
        chk("rst_busy3",  b_busy,   0);
        tick();
        rst = 1'b1;

        // m0 write 0xDEADBEEF to 0x10
        a_m0_req = 1; a_m0_we = 1; a_m0_addr = 32'h10; a_m0_wdata = 32'hDEADBEEF;
        tick();
        chk("t1_mem_en",    a_mem_en, 1);
        chk("t1_mem_we",    a_mem_we, 1);
        chk("t1_mem_addr",  a_mem_addr, 32'h10);
        chk("t1_mem_wdata", a_mem_wdata, 32'hDEADBEEF);
        chk("t1_busy",      a_busy, 1);
        chk("t1_owner",     a_owner, 0);
        chk("t1_ack_early", a_m0_ack, 0);
        tick();
        chk("t1_mem_en_off", a_mem_en, 0);
        chk("t1_m0_ack",     a_m0_ack, 1);
        chk("t1_m1_ack",     a_m1_ack, 0);
        a_m0_req = 0;
        tick();
        chk("t1_ack_clr",  a_m0_ack, 0);
        chk("t1_idle",     a_busy, 0);
        chk("t1_addr_hld", a_mem_addr, 32'h10);

        // m1 read of 0x10, latency 1
        a_m1_req = 1; a_m1_we = 0; a_m1_addr = 32'h10;
        tick();
        chk("t2_mem_en", a_mem_en, 1);
        chk("t2_mem_we", a_mem_we, 0);
        chk("t2_owner",  a_owner, 1);
        tick();
        chk("t2_mem_en_off", a_mem_en, 0);
        chk("t2_ack_early",  a_m1_ack, 0);
        chk("t2_busy",       a_busy, 1);
        tick();
        chk("t2_m1_ack",   a_m1_ack, 1);
        chk("t2_m1_rdata", a_m1_rdata, 32'hDEADBEEF);
        chk("t2_m0_ack",   a_m0_ack, 0);
        chk("t2_m0_rdata", a_m0_rdata, 0);
        a_m1_req = 0;
        tick();
        chk("t2_ack_clr",  a_m1_ack, 0);
        chk("t2_idle",     a_busy, 0);
        chk("t2_rdata_hld", a_m1_rdata, 32'hDEADBEEF);

        // Both masters writing continuously: grants alternate m0, m1, m0, m1
        a_m0_req = 1; a_m0_we = 1; a_m0_addr = 32'h20; a_m0_wdata = 32'h11111111;
        a_m1_req = 1; a_m1_we = 1; a_m1_addr = 32'h24; a_m1_wdata = 32'h22222222;
        tick();
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("t3_owner%0d", g),  a_owner, g % 2);
            chk($sformatf("t3_mem_en%0d", g), a_mem_en, 1);
            chk($sformatf("t3_addr%0d", g),   a_mem_addr, (g % 2) ? 32'h24 : 32'h20);
            tick();
            chk($sformatf("t3_ack%0d", g),   (g % 2) ? a_m1_ack : a_m0_ack, 1);
            chk($sformatf("t3_other%0d", g), (g % 2) ? a_m0_ack : a_m1_ack, 0);
            if (g % 2) a_m1_req = 0; else a_m0_req = 0;
            tick();
            chk($sformatf("t3_gap%0d", g), {a_busy, a_mem_en}, 0);
            if (g == 3) begin
                a_m0_req = 0; a_m1_req = 0;
            end else if (g % 2) a_m1_req = 1;
            else a_m0_req = 1;
            tick();
        end
        chk("t3_quiet", {a_busy, a_mem_en}, 0);

        // RD_LATENCY=3 read by m0 of 0x30 on dut3
        b_m0_req = 1; b_m0_we = 0; b_m0_addr = 32'h30;
        tick();
        chk("t4_mem_en", b_mem_en, 1);
        chk("t4_owner",  b_owner, 0);
        tick();
        chk("t4_w1", {b_busy, b_m0_ack, b_mem_en}, 3'b100);
        tick();
        chk("t4_w2", {b_busy, b_m0_ack}, 2'b10);
        tick();
        chk("t4_w3", {b_busy, b_m0_ack}, 2'b10);
        chk("t4_no_early_cap", b_m0_rdata, 0);
        tick();
        chk("t4_ack",   b_m0_ack, 1);
        chk("t4_rdata", b_m0_rdata, 32'h0030FFCF);
        chk("t4_m1_ack", b_m1_ack, 0);
        b_m0_req = 0;
        tick();
        chk("t4_idle", {b_busy, b_m0_ack}, 0);

        // Reset in the middle of an m1 read, then a tie goes to m0
        a_m1_req = 1; a_m1_we = 0; a_m1_addr = 32'h10;
        tick();
        chk("t5_owner", a_owner, 1);
        tick();
        chk("t5_wait_busy", a_busy, 1);
        a_m0_req = 1; a_m0_we = 1; a_m0_addr = 32'h40; a_m0_wdata = 32'h12345678;
        #2 rst = 1'b0;
        #1;
        chk("t5_async_busy",  a_busy, 0);
        chk("t5_async_owner", a_owner, 0);
        chk("t5_async_rdata", a_m1_rdata, 0);
        chk("t5_async_addr",  a_mem_addr, 0);
        tick();
        chk("t5_no_ack", {a_m0_ack, a_m1_ack}, 0);
        rst = 1'b1;
        tick();
        chk("t5_tie_owner", a_owner, 0);
        chk("t5_tie_en",    a_mem_en, 1);
        chk("t5_tie_addr",  a_mem_addr, 32'h40);
        a_m1_req = 0;
        tick();
        chk("t5_m0_ack", {a_m0_ack, a_m1_ack}, 2'b10);
        a_m0_req = 0;
        tick();
        chk("t5_idle", a_busy, 0);

        // m0 drops req during ISSUE; the read still completes once
        a_m0_req = 1; a_m0_we = 0; a_m0_addr = 32'h10;
        tick();
        chk("t6_issue", {a_mem_en, a_owner}, 2'b10);
        a_m0_req = 0;
        tick();
        chk("t6_wait", {a_busy, a_m0_ack}, 2'b10);
        tick();
        chk("t6_ack",   a_m0_ack, 1);
        chk("t6_rdata", a_m0_rdata, 32'hDEADBEEF);
        tick();
        chk("t6_ack_once", a_m0_ack, 0);
        chk("t6_idle",     a_busy, 0);
        chk("t6_rdata_hld", a_m0_rdata, 32'hDEADBEEF);
        tick();
        chk("t6_stay_idle", {a_busy, a_mem_en, a_m0_ack}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
